fp_normalize: RTL and testbench

Two-stage pipelined normalizer for the FPU datapath. Takes an unnormalized 24-bit significand, its biased exponent, sign and the leading-zero count produced upstream by the leading-zero counter. It applies that count as a left shift, clamped by the exponent for subnormal results, and packs an IEEE-754 single-precision word. It sits after the adder/subtractor significand path and before result writeback, with valid/ready handshakes on both sides.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fp_lshift24.sv | 20 ++
 rtl/fp_normalize.sv | 146 ++++++++++++++
 tb/tb_fp_normalize.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the single-precision datapath.
// Holds field widths, special encodings and the packed result layout.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;
  localparam int BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-2:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    K_NORM,
    K_SUB,
    K_ZERO,
    K_SPEC
  } kind_e;

  // Left-shift amounts never exceed 23 for a 24-bit significand.
  function automatic logic [4:0] sat_sh(
    input logic [8:0] v
  );
    return (v > 9'd23) ? 5'd23 : v[4:0];
  endfunction

endpackage

// File: rtl/fp_lshift24.sv
// 24-bit logarithmic left barrel shifter, five levels, zero fill.
// Ports: a_i operand, sh_i shift amount (0..31), y_o shifted result.
module fp_lshift24 (
  input  logic [23:0] a_i,
  input  logic [4:0]  sh_i,
  output logic [23:0] y_o
);

  logic [23:0] l0;
  logic [23:0] l1;
  logic [23:0] l2;
  logic [23:0] l3;

  assign l0  = sh_i[0] ? {a_i[22:0], 1'b0}  : a_i;
  assign l1  = sh_i[1] ? {l0[21:0], 2'b0}   : l0;
  assign l2  = sh_i[2] ? {l1[19:0], 4'b0}   : l1;
  assign l3  = sh_i[3] ? {l2[15:0], 8'b0}   : l2;
  assign y_o = sh_i[4] ? {l3[7:0], 16'b0}   : l3;

endmodule

// File: rtl/fp_normalize.sv
// Two-stage normalizer: applies the leading-zero shift, clamps for
// subnormals and packs an IEEE-754 single word behind valid/ready.
// Ports: clk, rst (async high); in_* beat with in_valid/in_ready;
// out_* result with out_valid/out_ready plus zero/denorm flags.
module fp_normalize
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [4:0]        in_lzc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_zero,
  output logic              out_denorm
);

  logic s2_adv;
  logic s1_adv;

  logic              s1_valid_q;
  logic              s1_sign_q;
  logic [MANT_W-1:0] s1_mant_q;
  logic [4:0]        s1_sh_q;
  logic [EXP_W-1:0]  s1_exp_q;
  kind_e             s1_kind_q;

  logic              s2_valid_q;
  fp32_t             s2_res_q;
  logic              s2_zero_q;
  logic              s2_denorm_q;

  kind_e             kind_d;
  logic [4:0]        sh_d;
  logic [EXP_W-1:0]  exp_d;
  logic [8:0]        ediff;
  logic [8:0]        esub;

  logic [MANT_W-1:0] shifted;
  fp32_t             res_d;
  logic              zero_d;
  logic              denorm_d;
  logic              unused_bits;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv & ~rst;

  // Both differences are non-negative on the paths that use them.
  assign ediff = {1'b0, in_exp} - {4'b0, in_lzc};
  assign esub  = {1'b0, in_exp} - 9'd1;

  always_comb begin
    kind_d = K_NORM;
    sh_d   = '0;
    exp_d  = '0;
    priority case (1'b1)
      (in_exp == EXP_MAX): kind_d = K_SPEC;
      (in_mant == '0 || in_lzc >= 5'd24): kind_d = K_ZERO;
      (in_exp == '0): kind_d = K_SUB;
      ({3'b0, in_lzc} < in_exp): begin
        kind_d = K_NORM;
        sh_d   = sat_sh({4'b0, in_lzc});
        exp_d  = ediff[EXP_W-1:0];
      end
      default: begin
        // Exponent would underflow: stop at the subnormal boundary.
        kind_d = K_SUB;
        sh_d   = sat_sh(esub);
      end
    endcase
  end

  fp_lshift24 u_shift (
    .a_i  (s1_mant_q),
    .sh_i (s1_sh_q),
    .y_o  (shifted)
  );

  always_comb begin
    res_d = '0;
    unique case (s1_kind_q)
      K_NORM: res_d = '{s1_sign_q, s1_exp_q, shifted[22:0]};
      K_SUB:  res_d = '{s1_sign_q, 8'h00, shifted[22:0]};
      K_ZERO: res_d = '{s1_sign_q, 8'h00, 23'h0};
      K_SPEC: begin
        if (s1_mant_q == '0)
          res_d = '{s1_sign_q, EXP_MAX, 23'h0};
        else
          res_d = QNAN;
      end
      default: res_d = '0;
    endcase
  end

  assign zero_d   = (res_d.exp == '0) && (res_d.frac == '0);
  assign denorm_d = (res_d.exp == '0) && (res_d.frac != '0);

  assign unused_bits = ^{ediff[8], shifted[23]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mant_q   <= '0;
      s1_sh_q     <= '0;
      s1_exp_q    <= '0;
      s1_kind_q   <= K_NORM;
      s2_valid_q  <= 1'b0;
      s2_res_q    <= '0;
      s2_zero_q   <= 1'b0;
      s2_denorm_q <= 1'b0;
    end else begin
      if (s1_adv)
        s1_valid_q <= in_valid;
      if (s1_adv && in_valid) begin
        s1_sign_q <= in_sign;
        s1_mant_q <= in_mant;
        s1_sh_q   <= sh_d;
        s1_exp_q  <= exp_d;
        s1_kind_q <= kind_d;
      end
      if (s2_adv)
        s2_valid_q <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        s2_res_q    <= res_d;
        s2_zero_q   <= zero_d;
        s2_denorm_q <= denorm_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_res_q;
  assign out_zero   = s2_zero_q;
  assign out_denorm = s2_denorm_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Bench for fp_normalize: directed cases, backpressure, reset flush
// and random beats against a value-level normalization model.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_mant;
  logic [4:0]  in_lzc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_denorm;

  int n_chk  = 0;
  int n_pass = 0;
  logic [33:0] exp_q[$];
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  fp_normalize #(
    .EXP_W  (8),
    .MANT_W (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_lzc     (in_lzc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_denorm (out_denorm)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] want
  );
    n_chk++;
    if (got === want)
      n_pass++;
    else
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
  endtask

  // Value-level model: shift left while the leading bit is clear
  // and the exponent can still drop; result is {zero,denorm,word}.
  function automatic logic [33:0] ref_fp(
    input logic        s,
    input logic [7:0]  e_in,
    input logic [23:0] m,
    input logic [4:0]  l
  );
    logic [31:0] r;
    logic [23:0] mm;
    int          e;
    if (e_in == 8'hFF)
      r = (m == 0) ? {s, 8'hFF, 23'h0} : 32'h7FC00000;
    else if (m == 0 || l >= 24)
      r = {s, 31'h0};
    else begin
      mm = m;
      e  = int'(e_in);
      while (!mm[23] && e > 1) begin
        mm = mm << 1;
        e--;
      end
      r = {s, (mm[23] ? 8'(e) : 8'h00), mm[22:0]};
    end
    return {r[30:0] == 0,
            (r[30:23] == 0) && (r[22:0] != 0), r};
  endfunction

  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0)
        chk("orphan", 64'(out_valid), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("result",
            64'({out_zero, out_denorm, out_result}),
            64'(e));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(
    input logic        s,
    input logic [7:0]  e,
    input logic [23:0] m,
    input logic [4:0]  l,
    input logic [33:0] x
  );
    int   n;
    logic acc;
    n        = 0;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_lzc   = l;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (acc)
        exp_q.push_back(x);
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc)
      chk("send_tmo", 64'(acc), 64'd1);
  endtask

  task automatic gen_send();
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    int          sh;
    sh = $urandom_range(0, 24);
    m  = {1'b1, 23'($urandom)} >> sh;
    s  = 1'($urandom);
    case ($urandom_range(0, 3))
      0: e = 8'($urandom_range(0, 30));
      1: e = 8'hFF;
      2: e = 8'h00;
      default: e = 8'($urandom_range(0, 255));
    endcase
    send(s, e, m, 5'(sh), ref_fp(s, e, m, 5'(sh)));
  endtask

  task automatic drain();
    int n;
    n        = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic [4:0]  l;
    logic [33:0] x;
  } dvec_t;

  dvec_t dir[7];

  initial begin
    dir[0] = '{1'b0, 8'd100, 24'h000800, 5'd12,
               {2'b00, 32'h2C000000}};
    dir[1] = '{1'b0, 8'd10, 24'h000001, 5'd23,
               {2'b01, 32'h00000200}};
    dir[2] = '{1'b1, 8'd50, 24'h000000, 5'd24,
               {2'b10, 32'h80000000}};
    dir[3] = '{1'b0, 8'hFF, 24'h000000, 5'd24,
               {2'b00, 32'h7F800000}};
    dir[4] = '{1'b1, 8'hFF, 24'hC00000, 5'd0,
               {2'b00, 32'h7FC00000}};
    dir[5] = '{1'b0, 8'd1, 24'h400000, 5'd1,
               {2'b01, 32'h00400000}};
    dir[6] = '{1'b0, 8'd24, 24'h000001, 5'd23,
               {2'b00, 32'h00800000}};

    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_lzc    = '0;
    out_ready = 1'b1;

    #12;
    chk("rst_ovld", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(out_result), 64'd0);
    chk("rst_flags", 64'({out_zero, out_denorm}), 64'd0);
    chk("rst_irdy", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(1'b0, 8'd127, 24'h800000, 5'd0,
         {2'b00, 32'h3F800000});
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_n2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    drain();

    foreach (dir[i])
      send(dir[i].s, dir[i].e, dir[i].m, dir[i].l, dir[i].x);
    drain();

    out_ready = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join_none
    gen_send();
    gen_send();
    in_valid = 1'b1;
    #1;
    chk("full_irdy", 64'(in_ready), 64'd0);
    chk("full_ovld", 64'(out_valid), 64'd1);
    repeat (3) gen_send();
    drain();

    out_ready = 1'b0;
    gen_send();
    gen_send();
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("mid_ovld", 64'(out_valid), 64'd0);
    chk("mid_res", 64'(out_result), 64'd0);
    chk("mid_irdy", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst", 64'(out_valid), 64'd0);

    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      gen_send();
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
